mold_rtx_req: RTL and testbench
===============================

MOLD_RTX_REQ -- requirements
Module: mold_rtx_req

Interface
REQ-001 Parameter SID_W, default 80, session id width (10 bytes).
REQ-002 Parameter SEQ_NUM_W, default 64, sequence number width.
REQ-003 Parameter ML_W, default 16, request message-count field width.
REQ-004 Parameter THROTTLE_CYC, default 16, idle cycles between request packets (used only under RTX_REQ_THROTTLE_EN).
REQ-005 Port clk, input, 1, single clock; all logic on posedge.
REQ-006 Port nreset, input, 1, reset, synchronous and active-low.
REQ-007 Port req_v_i, input, 1, miss request valid.
REQ-008 Port req_ready_o, output, 1, request accepted when req_v_i & req_ready_o.
REQ-009 Port req_sid_i, input, SID_W, session of missed range.
REQ-010 Port req_seq_num_start_i, input, SEQ_NUM_W, first missed sequence number.
REQ-011 Port req_seq_num_cnt_i, input, SEQ_NUM_W, number of missed messages.
REQ-012 Port tx_v_o, output, 1, request packet beat valid.
REQ-013 Port tx_ready_i, input, 1, beat consumed when tx_v_o & tx_ready_i.
REQ-014 Port tx_data_o, output, 64, beat payload; byte 0 in bits [7:0].
REQ-015 Port tx_keep_o, output, 8, byte-valid mask.
REQ-016 Port tx_last_o, output, 1, final beat of packet.

Function
REQ-017 Each request packet SHALL be 20 bytes big-endian: session (10), sequence number (8), message count (2).
REQ-018 Beat 0 SHALL carry sid[79:16], keep 8'hFF; beat 1 sid[15:0] then seq[63:16], keep 8'hFF; beat 2 seq[15:0] then count[15:0], keep 8'h0F, tx_last_o=1.
REQ-019 FSM states SHALL be IDLE, BEAT0, BEAT1, BEAT2 (plus GAP under RTX_REQ_THROTTLE_EN); IDLE->BEAT0 on accept or pending remainder, BEATn->next on tx handshake, BEAT2->IDLE (or GAP).
REQ-020 req_ready_o SHALL be 1 only in IDLE with no remainder pending; beat 0 SHALL be valid the cycle after acceptance.
REQ-021 Per packet count SHALL be min(remaining, 16'hFFFF); after BEAT2 handshake remaining -= count and seq += count modulo 2^64, session unchanged.
REQ-022 Remaining > 0 after BEAT2 SHALL start the next packet without a new request; remaining == 0 returns to ready.
REQ-023 A request with cnt == 0 SHALL be accepted and produce no packet.
REQ-024 While tx_v_o & ~tx_ready_i, tx_data_o/keep/last SHALL hold stable; tx_v_o SHALL not drop until handshake.
REQ-025 tx_keep_o and tx_last_o SHALL be 0 whenever tx_v_o is 0.

Reset
REQ-026 nreset low SHALL force IDLE, remaining=0, tx_v_o=0, tx_last_o=0, tx_keep_o=0, tx_data_o=0, req_ready_o=0 during reset, 1 the cycle after release.
REQ-027 Reset mid-packet SHALL abandon the packet and remainder; no trailing beats after release.

Configuration
REQ-028 With RTX_REQ_THROTTLE_EN defined, after each BEAT2 handshake the FSM SHALL spend exactly THROTTLE_CYC cycles in GAP (tx_v_o=0, req_ready_o=0) before the next packet or ready.
REQ-029 Without RTX_REQ_THROTTLE_EN, GAP and its counter SHALL not exist; next packet beat 0 or ready SHALL follow BEAT2 handshake in the next cycle.

Structure
REQ-030 Shared package mold_pkg SHALL hold SID_W/SEQ_NUM_W/ML_W constants, request header byte offsets, MAX_REQ_CNT=16'hFFFF and the FSM state enum.
REQ-031 One sub-module mold_rtx_ser SHALL implement the combinational beat mux (state, sid, seq, count -> data/keep/last); FSM and counters stay in mold_rtx_req.

Verification
REQ-032 sid=80'h0102..0A, seq=64'h10, cnt=5, tx_ready_i=1 -> 3 beats, beat2 data bytes 00 10 00 05, keep 8'h0F, last=1.
REQ-033 cnt=64'h1_0001, seq=0 -> packets count FFFF seq 0, then count 0002 seq 0xFFFF; req_ready_o low throughout.
REQ-034 seq=64'hFFFF_FFFF_FFFF_FFFF, cnt=64'h1_0000 -> second packet seq 64'hFFFE, count 1, same sid.
REQ-035 tx_ready_i toggled 0/1 per cycle -> each beat held stable until handshake, 3 handshakes total.
REQ-036 cnt=0 -> no tx_v_o, req_ready_o high next cycle; nreset pulsed during BEAT1 -> tx_v_o=0 after reset, no beat2.
REQ-037 RTX_REQ_THROTTLE_EN, THROTTLE_CYC=4, two back-to-back requests -> exactly 4 idle cycles between last and next beat 0.

Source files
------------

// File: rtl/mold_pkg.sv
// mold_pkg -- shared definitions for the MoldUDP64 retransmit-request path.
//
// Holds the default field widths, the byte layout of the 20-byte request
// packet (session, sequence number, message count, all big-endian), the
// per-packet message-count ceiling, the request FSM state encoding and a
// byte-swap helper used to place big-endian header bytes on a little-endian
// (byte 0 in bits [7:0]) streaming bus.
//
// Optional feature macro: RTX_REQ_THROTTLE_EN adds the GAP state.

package mold_pkg;

  localparam int SID_W     = 80;
  localparam int SEQ_NUM_W = 64;
  localparam int ML_W      = 16;

  // Byte offsets of each field inside the request packet.
  localparam int REQ_SID_OFF = 0;
  localparam int REQ_SEQ_OFF = 10;
  localparam int REQ_CNT_OFF = 18;
  localparam int REQ_LEN     = 20;

  localparam logic [15:0] MAX_REQ_CNT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BEAT0 = 3'd1,
    ST_BEAT1 = 3'd2,
    ST_BEAT2 = 3'd3
`ifdef RTX_REQ_THROTTLE_EN
    ,
    ST_GAP   = 3'd4
`endif
  } rtx_state_e;

  // Reverse byte order: the most significant byte of v lands in bits [7:0].
  function automatic logic [63:0] bswap64(input logic [63:0] v);
    logic [63:0] r;
    r = 64'h0;
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = v[63-8*i -: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mold_rtx_ser.sv
// mold_rtx_ser -- combinational beat mux for one retransmit-request packet.
//
// The 20 header bytes are laid out big-endian and padded to three 64-bit
// beats; the current FSM state selects which beat is presented.
//
// Ports:
//   state : current request FSM state (BEAT0..BEAT2 select a beat)
//   sid   : session id of the packet
//   seq   : first sequence number of the packet
//   cnt   : message count of the packet
//   data  : beat payload, byte 0 in bits [7:0]; zero outside beats
//   keep  : byte-valid mask; zero outside beats
//   last  : high on the final beat only

module mold_rtx_ser
  import mold_pkg::*;
(
  input  rtx_state_e           state,
  input  logic [SID_W-1:0]     sid,
  input  logic [SEQ_NUM_W-1:0] seq,
  input  logic [ML_W-1:0]      cnt,
  output logic [63:0]          data,
  output logic [7:0]           keep,
  output logic                 last
);

  localparam int HDR_W = 8 * REQ_LEN;
  localparam int PAD_W = 3 * 64 - HDR_W;

  logic [HDR_W-1:0] hdr_s;
  logic [191:0]     frame_s;

  // Place each field at its byte offset, first byte at the MSB end.
  always_comb begin
    hdr_s = {HDR_W{1'b0}};
    hdr_s[HDR_W-8*REQ_SID_OFF-1 -: SID_W]     = sid;
    hdr_s[HDR_W-8*REQ_SEQ_OFF-1 -: SEQ_NUM_W] = seq;
    hdr_s[HDR_W-8*REQ_CNT_OFF-1 -: ML_W]      = cnt;
  end

  assign frame_s = {hdr_s, {PAD_W{1'b0}}};

  // Select the beat for the current state; bytes go out in header order.
  always_comb begin
    data = 64'h0;
    keep = 8'h00;
    last = 1'b0;
    case (state)
      ST_BEAT0: begin
        data = bswap64(frame_s[191 -: 64]);
        keep = 8'hFF;
      end
      ST_BEAT1: begin
        data = bswap64(frame_s[127 -: 64]);
        keep = 8'hFF;
      end
      ST_BEAT2: begin
        data = bswap64(frame_s[63 -: 64]);
        keep = 8'h0F;
        last = 1'b1;
      end
      default: begin
        data = 64'h0;
        keep = 8'h00;
        last = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mold_rtx_req.sv
// mold_rtx_req -- turns a missed sequence range into MoldUDP64 request packets.
//
// A request (session, start sequence, count) is split into packets of at
// most 16'hFFFF messages each; every packet is three 64-bit beats. The next
// packet of the same request starts without a new request until the range
// is exhausted. A zero-count request is accepted and produces nothing.
//
// Ports:
//   clk, nreset          : clock, synchronous active-low reset
//   req_v_i/req_ready_o  : miss request handshake
//   req_sid_i            : session of the missed range
//   req_seq_num_start_i  : first missed sequence number
//   req_seq_num_cnt_i    : number of missed messages
//   tx_v_o/tx_ready_i    : request packet beat handshake
//   tx_data_o/keep/last  : beat payload, byte mask, end of packet
//
// Optional feature macro: RTX_REQ_THROTTLE_EN inserts THROTTLE_CYC idle
// cycles (GAP state) after every packet.

module mold_rtx_req #(
  parameter int SID_W        = mold_pkg::SID_W,
  parameter int SEQ_NUM_W    = mold_pkg::SEQ_NUM_W,
  parameter int ML_W         = mold_pkg::ML_W,
  parameter int THROTTLE_CYC = 16
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 req_v_i,
  output logic                 req_ready_o,
  input  logic [SID_W-1:0]     req_sid_i,
  input  logic [SEQ_NUM_W-1:0] req_seq_num_start_i,
  input  logic [SEQ_NUM_W-1:0] req_seq_num_cnt_i,
  output logic                 tx_v_o,
  input  logic                 tx_ready_i,
  output logic [63:0]          tx_data_o,
  output logic [7:0]           tx_keep_o,
  output logic                 tx_last_o
);

  import mold_pkg::*;

  rtx_state_e           state_r, state_nxt;
  logic [SID_W-1:0]     sid_r, sid_nxt;
  logic [SEQ_NUM_W-1:0] seq_r, seq_nxt;
  logic [SEQ_NUM_W-1:0] rem_r, rem_nxt;
  logic [ML_W-1:0]      pkt_cnt_s;
  logic                 ready_r, ready_nxt;
  logic                 accept_s;
  logic                 tx_hs_s;

  // A gap length below one cycle has no meaning; flag it in the hierarchy.
  if (THROTTLE_CYC < 1) begin : g_throttle_cyc_below_one
  end

`ifdef RTX_REQ_THROTTLE_EN
  localparam int GAP_W = (THROTTLE_CYC > 1) ? $clog2(THROTTLE_CYC) : 1;
  logic [GAP_W-1:0] gap_r, gap_nxt;
`endif

  // Ready is registered so it reads 0 throughout reset and 1 right after.
  assign req_ready_o = ready_r;
  assign accept_s    = req_v_i & ready_r;
  assign tx_v_o      = (state_r == ST_BEAT0) || (state_r == ST_BEAT1) ||
                       (state_r == ST_BEAT2);
  assign tx_hs_s     = tx_v_o & tx_ready_i;

  // Messages carried by the current packet: the remainder, capped.
  always_comb begin
    if (rem_r > SEQ_NUM_W'(MAX_REQ_CNT)) begin
      pkt_cnt_s = ML_W'(MAX_REQ_CNT);
    end else begin
      pkt_cnt_s = rem_r[ML_W-1:0];
    end
  end

  // Next-state, range bookkeeping and ready computation.
  always_comb begin
    state_nxt = state_r;
    sid_nxt   = sid_r;
    seq_nxt   = seq_r;
    rem_nxt   = rem_r;
`ifdef RTX_REQ_THROTTLE_EN
    gap_nxt   = gap_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          sid_nxt = req_sid_i;
          seq_nxt = req_seq_num_start_i;
          rem_nxt = req_seq_num_cnt_i;
          if (req_seq_num_cnt_i != {SEQ_NUM_W{1'b0}}) begin
            state_nxt = ST_BEAT0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (rem_r != {SEQ_NUM_W{1'b0}}) begin
          state_nxt = ST_BEAT0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_BEAT0: begin
        if (tx_hs_s) begin
          state_nxt = ST_BEAT1;
        end else begin
          state_nxt = ST_BEAT0;
        end
      end
      ST_BEAT1: begin
        if (tx_hs_s) begin
          state_nxt = ST_BEAT2;
        end else begin
          state_nxt = ST_BEAT1;
        end
      end
      ST_BEAT2: begin
        if (tx_hs_s) begin
          rem_nxt = rem_r - SEQ_NUM_W'(pkt_cnt_s);
          seq_nxt = seq_r + SEQ_NUM_W'(pkt_cnt_s);
`ifdef RTX_REQ_THROTTLE_EN
          state_nxt = ST_GAP;
          gap_nxt   = GAP_W'(THROTTLE_CYC - 1);
`else
          if (rem_nxt != {SEQ_NUM_W{1'b0}}) begin
            state_nxt = ST_BEAT0;
          end else begin
            state_nxt = ST_IDLE;
          end
`endif
        end else begin
          state_nxt = ST_BEAT2;
        end
      end
`ifdef RTX_REQ_THROTTLE_EN
      ST_GAP: begin
        if (gap_r == {GAP_W{1'b0}}) begin
          if (rem_r != {SEQ_NUM_W{1'b0}}) begin
            state_nxt = ST_BEAT0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          gap_nxt = gap_r - {{(GAP_W-1){1'b0}}, 1'b1};
        end
      end
`endif
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    ready_nxt = (state_nxt == ST_IDLE) && (rem_nxt == {SEQ_NUM_W{1'b0}});
  end

  // State and range registers; reset drops any packet and remainder.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_r <= ST_IDLE;
      sid_r   <= {SID_W{1'b0}};
      seq_r   <= {SEQ_NUM_W{1'b0}};
      rem_r   <= {SEQ_NUM_W{1'b0}};
      ready_r <= 1'b0;
`ifdef RTX_REQ_THROTTLE_EN
      gap_r   <= {GAP_W{1'b0}};
`endif
    end else begin
      state_r <= state_nxt;
      sid_r   <= sid_nxt;
      seq_r   <= seq_nxt;
      rem_r   <= rem_nxt;
      ready_r <= ready_nxt;
`ifdef RTX_REQ_THROTTLE_EN
      gap_r   <= gap_nxt;
`endif
    end
  end

  mold_rtx_ser u_ser (
    .state (state_r),
    .sid   (sid_r),
    .seq   (seq_r),
    .cnt   (pkt_cnt_s),
    .data  (tx_data_o),
    .keep  (tx_keep_o),
    .last  (tx_last_o)
  );

endmodule

// File: tb/tb_mold_rtx_req.sv
// tb_mold_rtx_req -- directed self-checking bench for mold_rtx_req.

module tb_mold_rtx_req;

`ifdef RTX_REQ_THROTTLE_EN
  localparam int EXP_GAP   = 4;
  localparam bit THR_ON    = 1'b1;
`else
  localparam int EXP_GAP   = 0;
  localparam bit THR_ON    = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nreset;
  logic        req_v_i;
  logic        req_ready_o;
  logic [79:0] req_sid_i;
  logic [63:0] req_seq_num_start_i;
  logic [63:0] req_seq_num_cnt_i;
  logic        tx_v_o;
  logic        tx_ready_i;
  logic [63:0] tx_data_o;
  logic [7:0]  tx_keep_o;
  logic        tx_last_o;

  always #5 clk = ~clk;

  mold_rtx_req #(.THROTTLE_CYC(4)) dut (
    .clk                 (clk),
    .nreset              (nreset),
    .req_v_i             (req_v_i),
    .req_ready_o         (req_ready_o),
    .req_sid_i           (req_sid_i),
    .req_seq_num_start_i (req_seq_num_start_i),
    .req_seq_num_cnt_i   (req_seq_num_cnt_i),
    .tx_v_o              (tx_v_o),
    .tx_ready_i          (tx_ready_i),
    .tx_data_o           (tx_data_o),
    .tx_keep_o           (tx_keep_o),
    .tx_last_o           (tx_last_o)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int idle_viol = 0;
  int stab_viol = 0;
  int stall_seen = 0;
  int ready_viol = 0;
  logic        prev_stall = 1'b0;
  logic [72:0] prev_beat;
  logic [72:0] q_beat[$];
  int          q_cyc[$];

  localparam logic [79:0] S1 = 80'h0102030405060708090A;
  localparam logic [79:0] S2 = 80'hA1A2A3A4A5A6A7A8A9AA;
  localparam logic [79:0] S3 = 80'hDEADBEEFCAFEF00D1234;

  always @(posedge clk) cyc <= cyc + 1;

  // Beat recorder plus stability and idle-quiet monitors.
  always @(negedge clk) begin
    if (!nreset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        stall_seen++;
        if (!tx_v_o || {tx_data_o, tx_keep_o, tx_last_o} !== prev_beat) stab_viol++;
      end
      if (!tx_v_o && (tx_keep_o !== 8'h00 || tx_last_o !== 1'b0)) idle_viol++;
      if (tx_v_o && tx_ready_i) begin
        q_beat.push_back({tx_data_o, tx_keep_o, tx_last_o});
        q_cyc.push_back(cyc);
      end
      prev_stall = tx_v_o & ~tx_ready_i;
      prev_beat  = {tx_data_o, tx_keep_o, tx_last_o};
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte-level model of one beat: 20 header bytes in wire order.
  function automatic logic [72:0] exp_beat(input logic [79:0] sid, input logic [63:0] seq,
                                           input logic [15:0] cnt, input int n);
    logic [7:0]  b [0:23];
    logic [63:0] d;
    for (int i = 0; i < 24; i++) b[i] = 8'h00;
    for (int i = 0; i < 10; i++) b[i] = sid[79-8*i -: 8];
    for (int i = 0; i < 8; i++) b[10+i] = seq[63-8*i -: 8];
    b[18] = cnt[15:8];
    b[19] = cnt[7:0];
    for (int k = 0; k < 8; k++) d[8*k +: 8] = b[8*n+k];
    return {d, (n == 2) ? 8'h0F : 8'hFF, (n == 2) ? 1'b1 : 1'b0};
  endfunction

  task automatic send_req(input logic [79:0] sid, input logic [63:0] seq, input logic [63:0] cnt);
    int w = 0;
    while (!req_ready_o && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check_eq("ready_before_send", req_ready_o, 1'b1);
    req_sid_i           = sid;
    req_seq_num_start_i = seq;
    req_seq_num_cnt_i   = cnt;
    req_v_i             = 1'b1;
    @(posedge clk); #1;
    req_v_i = 1'b0;
  endtask

  task automatic wait_beats(input string tag, input int target, input int budget);
    int n = 0;
    while (q_beat.size() < target && n < budget) begin
      @(posedge clk); #1;
      if (q_beat.size() < target && req_ready_o) ready_viol++;
      n++;
    end
    check_eq({tag, "_beat_count"}, q_beat.size(), target);
  endtask

  task automatic check_pkt(input string tag, input int idx, input logic [79:0] sid,
                           input logic [63:0] seq, input logic [15:0] cnt);
    for (int b = 0; b < 3; b++) begin
      check_eq($sformatf("%s_b%0d", tag, b), q_beat[idx+b], exp_beat(sid, seq, cnt, b));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=time limit reached expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int vcnt;
    nreset = 1'b0;
    req_v_i = 1'b0;
    req_sid_i = 80'h0;
    req_seq_num_start_i = 64'h0;
    req_seq_num_cnt_i = 64'h0;
    tx_ready_i = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx_v", tx_v_o, 1'b0);
    check_eq("rst_ready", req_ready_o, 1'b0);
    check_eq("rst_keep", tx_keep_o, 8'h00);
    check_eq("rst_last", tx_last_o, 1'b0);
    check_eq("rst_data", tx_data_o, 64'h0);
    nreset = 1'b1;
    check_eq("ready_before_first_edge", req_ready_o, 1'b0);
    @(posedge clk); #1;
    check_eq("ready_after_release", req_ready_o, 1'b1);

    // Basic 3-beat packet, hand-computed beats
    base = q_beat.size();
    send_req(S1, 64'h10, 64'd5);
    check_eq("t032_beat0_latency", tx_v_o, 1'b1);
    wait_beats("t032", base + 3, 20);
    check_eq("t032_b0", q_beat[base],   {64'h0807060504030201, 8'hFF, 1'b0});
    check_eq("t032_b1", q_beat[base+1], {64'h0000000000000A09, 8'hFF, 1'b0});
    check_eq("t032_b2", q_beat[base+2], {64'h0000000005001000, 8'h0F, 1'b1});
    check_eq("t032_ready_after", req_ready_o, !THR_ON);

    // Split into FFFF + 2
    base = q_beat.size();
    send_req(S2, 64'h0, 64'h1_0001);
    wait_beats("t033", base + 6, 40);
    check_pkt("t033_p0", base, S2, 64'h0, 16'hFFFF);
    check_pkt("t033_p1", base + 3, S2, 64'hFFFF, 16'h0002);
    check_eq("t033_p1_b2_hand", q_beat[base+5], {64'h000000000200FFFF, 8'h0F, 1'b1});
    check_eq("t033_gap", q_cyc[base+3] - q_cyc[base+2] - 1, EXP_GAP);

    // Sequence wrap modulo 2^64
    base = q_beat.size();
    send_req(S3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000);
    wait_beats("t034", base + 6, 40);
    check_pkt("t034_p0", base, S3, 64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF);
    check_pkt("t034_p1", base + 3, S3, 64'hFFFE, 16'h0001);
    check_eq("t034_p1_b2_hand", q_beat[base+5], {64'h000000000100FEFF, 8'h0F, 1'b1});

    // Backpressure: tx_ready toggles every cycle
    tx_ready_i = 1'b0;
    base = q_beat.size();
    send_req(S1, 64'h20, 64'd7);
    for (int i = 0; i < 40 && q_beat.size() < base + 3; i++) begin
      @(posedge clk); #1;
      tx_ready_i = ~tx_ready_i;
    end
    tx_ready_i = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check_eq("t035_hs_count", q_beat.size() - base, 3);
    check_pkt("t035", base, S1, 64'h20, 16'd7);

    // Zero-count request
    base = q_beat.size();
    send_req(S1, 64'h40, 64'd0);
    check_eq("t036_cnt0_no_valid", tx_v_o, 1'b0);
    check_eq("t036_cnt0_ready", req_ready_o, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check_eq("t036_cnt0_no_beats", q_beat.size() - base, 0);

    // Reset while in BEAT1
    base = q_beat.size();
    send_req(S1, 64'h50, 64'd3);
    @(posedge clk); #1;
    check_eq("t036_in_beat1_valid", tx_v_o, 1'b1);
    check_eq("t036_beat0_taken", q_beat.size() - base, 1);
    tx_ready_i = 1'b0;
    nreset = 1'b0;
    @(posedge clk); #1;
    check_eq("t036_rst_tx_v", tx_v_o, 1'b0);
    check_eq("t036_rst_keep", tx_keep_o, 8'h00);
    check_eq("t036_rst_last", tx_last_o, 1'b0);
    check_eq("t036_rst_ready", req_ready_o, 1'b0);
    nreset = 1'b1;
    tx_ready_i = 1'b1;
    vcnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (tx_v_o) vcnt++;
    end
    check_eq("t036_no_trailing_valid", vcnt, 0);
    check_eq("t036_no_trailing_beats", q_beat.size() - base, 1);
    check_eq("t036_ready_after_rst", req_ready_o, 1'b1);

    // Global monitors
    check_eq("ready_low_while_busy", ready_viol, 0);
    check_eq("idle_keep_last_zero", idle_viol, 0);
    check_eq("stall_stability", stab_viol, 0);
    check_eq("stall_exercised", stall_seen > 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
